// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with an integrated transmit FIFO.
// Frames leave back-to-back while the FIFO holds data.
//
// state    | meaning
// ---------+---------------------------------------------------
// S_IDLE   | line high, waiting for a FIFO entry
// S_START  | start bit (line low)
// S_DATA   | DATA_BITS data bits, LSB first
// S_PARITY | optional parity bit
// S_STOP   | STOP_BITS stop periods, may chain straight to START
module uart_tx_param #(
    parameter int CLK_DIV    = 217,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_valid,
    input  logic [DATA_BITS-1:0]          i_data,
    output logic                          o_ready,
    output logic                          o_tx,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [17:0]   LP_DIV    = 18'(CLK_DIV);
    localparam logic [17:0]   LP_STOP   = 18'(STOP_BITS * CLK_DIV);
    localparam logic [3:0]    LP_LAST   = 4'(DATA_BITS - 1);
    localparam logic [CW-1:0] LP_FULL   = CW'(FIFO_DEPTH);
    localparam logic          LP_PAR_EN = (PARITY != 0);
    localparam logic          LP_ODD    = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state;
    logic [17:0]           r_baud;
    logic [3:0]            r_bit;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_par;
    logic                  r_tx;
    logic                  r_busy;

    logic [DATA_BITS-1:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr;
    logic [AW-1:0]         r_rd;
    logic [CW-1:0]         r_count;
    logic                  r_ready;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_empty;
    logic                  w_stop_end;
    logic [DATA_BITS-1:0]  w_head;
    logic [CW-1:0]         w_count_nxt;

    assign w_push     = i_valid && r_ready;
    assign w_empty    = (r_count == '0);
    assign w_stop_end = (r_state == S_STOP) && (r_baud == LP_STOP);
    assign w_pop      = !w_empty && ((r_state == S_IDLE) || w_stop_end);
    assign w_head     = r_mem[r_rd];

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // Ready is registered from the next count so it tracks full without a comb path to i_valid.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_ready <= 1'b0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != LP_FULL);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
            r_baud  <= 18'd1;
            r_bit   <= 4'd0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_par   <= (^w_head) ^ LP_ODD;
                        r_tx    <= 1'b0;
                        r_baud  <= 18'd1;
                        r_busy  <= 1'b1;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_baud == LP_DIV) begin
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_bit   <= 4'd0;
                        r_baud  <= 18'd1;
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud + 18'd1;
                    end
                end
                S_DATA: begin
                    if (r_baud == LP_DIV) begin
                        r_baud <= 18'd1;
                        if (r_bit == LP_LAST) begin
                            if (LP_PAR_EN) begin
                                r_tx    <= r_par;
                                r_state <= S_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                            r_bit   <= r_bit + 4'd1;
                        end
                    end else begin
                        r_baud <= r_baud + 18'd1;
                    end
                end
                S_PARITY: begin
                    if (r_baud == LP_DIV) begin
                        r_tx    <= 1'b1;
                        r_baud  <= 18'd1;
                        r_state <= S_STOP;
                    end else begin
                        r_baud <= r_baud + 18'd1;
                    end
                end
                S_STOP: begin
                    if (w_stop_end) begin
                        r_baud <= 18'd1;
                        if (w_pop) begin
                            r_shift <= w_head;
                            r_par   <= (^w_head) ^ LP_ODD;
                            r_tx    <= 1'b0;
                            r_state <= S_START;
                        end else begin
                            r_tx    <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + 18'd1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_baud  <= 18'd1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_tx    = r_tx;
    assign o_busy  = r_busy;
    assign o_ready = r_ready;
    assign o_count = r_count;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: five instances cover 8N1, even/odd parity,
// 7-bit/2-stop framing, and a depth-4 FIFO for full, back-to-back and mid-frame reset.
module tb_uart_tx_param;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rst_e;
    logic [4:0] tb_valid;
    logic [8:0] tb_data;
    logic [2:0] sel;

    wire  [4:0] rdy;
    wire  [4:0] txs;
    wire  [4:0] bsy;
    wire  [4:0] cnt0, cnt1, cnt2, cnt3;
    wire  [2:0] cnt4;

    logic       tx_m, busy_m, rdy_m;
    logic [4:0] cnt_m;

    int n_tests;
    int n_fail;

    always #5 clk = ~clk;

    uart_tx_param #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u_a (
        .i_clk(clk), .i_rst(rst_n), .i_valid(tb_valid[0]), .i_data(tb_data[7:0]),
        .o_ready(rdy[0]), .o_tx(txs[0]), .o_busy(bsy[0]), .o_count(cnt0));
    uart_tx_param #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u_even (
        .i_clk(clk), .i_rst(rst_n), .i_valid(tb_valid[1]), .i_data(tb_data[7:0]),
        .o_ready(rdy[1]), .o_tx(txs[1]), .o_busy(bsy[1]), .o_count(cnt1));
    uart_tx_param #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) u_odd (
        .i_clk(clk), .i_rst(rst_n), .i_valid(tb_valid[2]), .i_data(tb_data[7:0]),
        .o_ready(rdy[2]), .o_tx(txs[2]), .o_busy(bsy[2]), .o_count(cnt2));
    uart_tx_param #(.CLK_DIV(DIV), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16)) u_7n2 (
        .i_clk(clk), .i_rst(rst_n), .i_valid(tb_valid[3]), .i_data(tb_data[6:0]),
        .o_ready(rdy[3]), .o_tx(txs[3]), .o_busy(bsy[3]), .o_count(cnt3));
    uart_tx_param #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_fifo (
        .i_clk(clk), .i_rst(rst_e), .i_valid(tb_valid[4]), .i_data(tb_data[7:0]),
        .o_ready(rdy[4]), .o_tx(txs[4]), .o_busy(bsy[4]), .o_count(cnt4));

    always_comb begin
        tx_m   = txs[sel];
        busy_m = bsy[sel];
        rdy_m  = rdy[sel];
        case (sel)
            3'd0:    cnt_m = cnt0;
            3'd1:    cnt_m = cnt1;
            3'd2:    cnt_m = cnt2;
            3'd3:    cnt_m = cnt3;
            3'd4:    cnt_m = {2'b00, cnt4};
            default: cnt_m = 5'd0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic write1(input int s, input logic [8:0] d);
        @(posedge clk); #1;
        tb_data     = d;
        tb_valid[s] = 1'b1;
        @(posedge clk); #1;
        tb_valid = 5'b0;
        tb_data  = 9'h1AA;
    endtask

    // Entered #1 after the edge that starts period 0; leaves #1 after the edge ending the frame.
    task automatic run_frame(input string tag, input logic [15:0] pat, input int n);
        for (int p = 0; p < n; p++) begin
            chk($sformatf("%s_b%0d_head", tag, p), 32'(tx_m), 32'(pat[p]));
            repeat (DIV - 1) @(posedge clk);
            #1;
            chk($sformatf("%s_b%0d_tail", tag, p), 32'(tx_m), 32'(pat[p]));
            chk($sformatf("%s_b%0d_busy", tag, p), 32'(busy_m), 32'd1);
            @(posedge clk); #1;
        end
    endtask

    task automatic single_frame(input string tag, input int s, input logic [8:0] d,
                                input logic [15:0] pat, input int n);
        sel = 3'(s);
        write1(s, d);
        chk({tag, "_cnt_after_write"}, 32'(cnt_m), 32'd1);
        chk({tag, "_busy_after_write"}, 32'(busy_m), 32'd0);
        chk({tag, "_tx_after_write"}, 32'(tx_m), 32'd1);
        @(posedge clk); #1;
        chk({tag, "_cnt_after_pop"}, 32'(cnt_m), 32'd0);
        run_frame(tag, pat, n);
        chk({tag, "_busy_end"}, 32'(busy_m), 32'd0);
        chk({tag, "_tx_end"}, 32'(tx_m), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] pat_e [5];
        int          cnt_e [5];
        int          act;

        pat_e = '{16'h340, 16'h342, 16'h344, 16'h346, 16'h348};
        cnt_e = '{1, 3, 2, 1, 0};
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        rst_e    = 1'b0;
        tb_valid = 5'b0;
        tb_data  = 9'h000;
        sel      = 3'd0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", 32'(txs), 32'h1F);
        chk("rst_busy", 32'(bsy), 32'h00);
        chk("rst_ready", 32'(rdy), 32'h00);
        chk("rst_count", 32'({cnt0, cnt1, cnt2, cnt3, cnt4}), 32'h0);
        rst_n = 1'b1;
        rst_e = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_release", 32'(rdy), 32'h1F);

        single_frame("8n1_55", 0, 9'h055, 16'h02AA, 10);
        single_frame("even_07", 1, 9'h007, 16'h060E, 11);
        single_frame("odd_07", 2, 9'h007, 16'h040E, 11);
        single_frame("7n2_41", 3, 9'h041, 16'h0382, 10);

        // FIFO fill with i_valid held high, frames checked concurrently.
        sel = 3'd4;
        @(posedge clk); #1;
        tb_valid[4] = 1'b1;
        tb_data     = 9'h0A0;
        fork
            begin
                @(posedge clk); #1;
                chk("fill_e1_cnt", 32'(cnt_m), 32'd1);
                chk("fill_e1_rdy", 32'(rdy_m), 32'd1);
                tb_data = 9'h0A1;
                @(posedge clk); #1;
                chk("fill_e2_cnt", 32'(cnt_m), 32'd1);
                tb_data = 9'h0A2;
                @(posedge clk); #1;
                chk("fill_e3_cnt", 32'(cnt_m), 32'd2);
                tb_data = 9'h0A3;
                @(posedge clk); #1;
                chk("fill_e4_cnt", 32'(cnt_m), 32'd3);
                chk("fill_e4_rdy", 32'(rdy_m), 32'd1);
                tb_data = 9'h0A4;
                @(posedge clk); #1;
                chk("fill_e5_cnt", 32'(cnt_m), 32'd4);
                chk("fill_e5_rdy", 32'(rdy_m), 32'd0);
                tb_data = 9'h0A5;
                @(posedge clk); #1;
                chk("full_hold_cnt", 32'(cnt_m), 32'd4);
                chk("full_hold_rdy", 32'(rdy_m), 32'd0);
                tb_valid = 5'b0;
                tb_data  = 9'h1AA;
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                for (int f = 0; f < 5; f++) begin
                    chk($sformatf("b2b_f%0d_cnt", f), 32'(cnt_m), 32'(cnt_e[f]));
                    chk($sformatf("b2b_f%0d_rdy", f), 32'(rdy_m), 32'd1);
                    run_frame($sformatf("b2b_f%0d", f), pat_e[f], 10);
                end
                chk("b2b_busy_end", 32'(busy_m), 32'd0);
                chk("b2b_tx_end", 32'(tx_m), 32'd1);
                chk("b2b_cnt_end", 32'(cnt_m), 32'd0);
            end
        join

        // Three words queued, reset during data bit 0 of the second frame.
        @(posedge clk); #1;
        tb_valid[4] = 1'b1;
        tb_data     = 9'h011;
        @(posedge clk); #1;
        tb_data = 9'h022;
        @(posedge clk); #1;
        tb_data = 9'h033;
        @(posedge clk); #1;
        tb_valid = 5'b0;
        tb_data  = 9'h1AA;
        chk("rstmid_cnt_queued", 32'(cnt_m), 32'd2);
        chk("rstmid_busy_f1", 32'(busy_m), 32'd1);
        repeat (44) @(posedge clk);
        #1;
        chk("rstmid_pre_tx", 32'(tx_m), 32'd0);
        chk("rstmid_pre_busy", 32'(busy_m), 32'd1);
        chk("rstmid_pre_cnt", 32'(cnt_m), 32'd1);
        rst_e = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_tx", 32'(tx_m), 32'd1);
        chk("rstmid_busy", 32'(busy_m), 32'd0);
        chk("rstmid_cnt", 32'(cnt_m), 32'd0);
        chk("rstmid_rdy", 32'(rdy_m), 32'd0);
        rst_e = 1'b1;
        @(posedge clk); #1;
        chk("rstmid_rdy_release", 32'(rdy_m), 32'd1);
        act = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (busy_m || !tx_m) act++;
        end
        chk("rstmid_no_frames", 32'(act), 32'd0);
        chk("rstmid_cnt_idle", 32'(cnt_m), 32'd0);

        single_frame("after_rst_5a", 4, 9'h05A, 16'h02B4, 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
